// File: rtl/ir_pkg.sv
// Shared definitions for the IR command transmitter: frame states, segment
// lengths in timing units, and the 100 MHz default timing parameters.
package ir_pkg;

    localparam int T_UNIT_DEFAULT     = 56000;
    localparam int CAR_PERIOD_DEFAULT = 2632;
    localparam int CAR_HIGH_DEFAULT   = 877;

    localparam int UNITS_LEAD_MARK  = 16;
    localparam int UNITS_LEAD_SPACE = 8;
    localparam int UNITS_BIT_MARK   = 1;
    localparam int UNITS_ZERO_SPACE = 1;
    localparam int UNITS_ONE_SPACE  = 3;
    localparam int UNITS_STOP_MARK  = 1;
    localparam int UNITS_GAP        = 18;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
        GAP
    } ir_state_e;

endpackage

// File: rtl/ir_carrier.sv
// Carrier generator: while en is high, car is high for the first CAR_HIGH
// cycles of every CAR_PERIOD; the phase restarts whenever en drops.
module ir_carrier
    import ir_pkg::*;
#(
    parameter int CAR_PERIOD = CAR_PERIOD_DEFAULT,
    parameter int CAR_HIGH   = CAR_HIGH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic car
);

    localparam int PH_W = (CAR_PERIOD > 1) ? $clog2(CAR_PERIOD) : 1;

    logic [PH_W-1:0] phase_q, phase_d;
    logic            car_q, car_d;

    // en describes the coming cycle, so phase_q is the phase that cycle will show
    always_comb begin
        phase_d = '0;
        car_d   = 1'b0;
        if (en) begin
            car_d   = (int'(phase_q) < CAR_HIGH);
            phase_d = (int'(phase_q) == CAR_PERIOD - 1) ? '0 : phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            car_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            car_q   <= car_d;
        end
    end

    assign car = car_q;

endmodule

// File: rtl/ir_tx.sv
// NEC-style IR frame transmitter: leader, 16 data bits (cmd then ~cmd, LSB
// first), stop mark and guard gap, with a carrier-modulated LED output.
module ir_tx
    import ir_pkg::*;
#(
    parameter int T_UNIT     = T_UNIT_DEFAULT,
    parameter int CAR_PERIOD = CAR_PERIOD_DEFAULT,
    parameter int CAR_HIGH   = CAR_HIGH_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] cmd,
    output logic       ir_line,
    output logic       ir_led,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = $clog2(UNITS_GAP * T_UNIT);

    ir_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       cmd_q, cmd_d;
    logic             line_q, line_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cur_bit;
    logic             mark_d;

    function automatic logic [CNT_W-1:0] units_last(input int units);
        return CNT_W'(units * T_UNIT - 1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        cur_bit = bit_q[3] ? ~cmd_q[bit_q[2:0]] : cmd_q[bit_q[2:0]];

        unique case (state_q)
            LEAD_MARK:  last = units_last(UNITS_LEAD_MARK);
            LEAD_SPACE: last = units_last(UNITS_LEAD_SPACE);
            BIT_MARK:   last = units_last(UNITS_BIT_MARK);
            BIT_SPACE:  last = units_last(cur_bit ? UNITS_ONE_SPACE : UNITS_ZERO_SPACE);
            STOP_MARK:  last = units_last(UNITS_STOP_MARK);
            GAP:        last = units_last(UNITS_GAP);
            default:    last = '0;
        endcase

        if (state_q == IDLE) begin
            if (send) begin
                state_d = LEAD_MARK;
                cmd_d   = cmd;
                cnt_d   = '0;
                bit_d   = '0;
            end
        end else if (cnt_q == last) begin
            cnt_d = '0;
            unique case (state_q)
                LEAD_MARK:  state_d = LEAD_SPACE;
                LEAD_SPACE: state_d = BIT_MARK;
                BIT_MARK:   state_d = BIT_SPACE;
                BIT_SPACE: begin
                    if (bit_q == 4'd15) begin
                        state_d = STOP_MARK;
                    end else begin
                        state_d = BIT_MARK;
                        bit_d   = bit_q + 4'd1;
                    end
                end
                STOP_MARK:  state_d = GAP;
                GAP:        state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are derived from the next state so they register in step with it
        mark_d = state_d inside {LEAD_MARK, BIT_MARK, STOP_MARK};
        line_d = ~mark_d;
        busy_d = (state_d != IDLE);
        done_d = (state_d == GAP) && (cnt_d == units_last(UNITS_GAP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    ir_carrier #(
        .CAR_PERIOD(CAR_PERIOD),
        .CAR_HIGH  (CAR_HIGH)
    ) u_carrier (
        .clk(clk),
        .rst(rst),
        .en (mark_d),
        .car(ir_led)
    );

    assign ir_line = line_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
